lsu_mem_ctrl: RTL and testbench

- Load/store control stage between the execute unit and the DPI data-memory port of the multi-cycle core; sits directly upstream of the memory block.
- Accepts one load or store request per handshake, checks alignment, and drives the memory read/write enables, address, data and write length for exactly one cycle.
- For loads, captures the raw 64-bit read data and returns a byte/half/word/double result, sign- or zero-extended, through a valid/ready response.

---
 rtl/lsu_mem_ctrl_pkg.sv | 45 ++++
 rtl/lsu_load_ext.sv | 28 ++
 rtl/lsu_mem_ctrl.sv | 106 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared configuration for the load/store control stage: widths, funct3
// encodings, state encodings and the request legality check.
package lsu_mem_ctrl_pkg;

  localparam int LSU_DATA_WIDTH = 64;
  localparam int LSU_BYTE_WIDTH = 8;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // A request that must not reach memory: an encoding with no defined
  // access, or an address that is not a multiple of the access size.
  function automatic logic req_faults(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [2:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal = write ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'd1:    misaligned = addr_lo[0];
      2'd2:    misaligned = (addr_lo[1:0] != 2'b00);
      2'd3:    misaligned = (addr_lo != 3'b000);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-result extraction: selects byte/half/word/double from
// the raw memory word and sign- or zero-extends it by funct3.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] result
);

  // Size/extension select; undefined encodings yield zero
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      F3_LH:   result = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      F3_LW:   result = {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
      F3_LD:   result = raw;
      F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      F3_LWU:  result = {{(DATA_WIDTH-32){1'b0}}, raw[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage: accepts one request, checks alignment, drives a
// single-cycle memory access and returns the (extended) result via a
// valid/ready response.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int BYTE_WIDTH = LSU_BYTE_WIDTH
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWrite,
  input  logic [2:0]            iReqFunct3,
  input  logic [DATA_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  output logic                  oRespValid,
  input  logic                  iRespReady,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespMisalign,
  output logic                  oMemRdEn,
  output logic [DATA_WIDTH-1:0] oMemRdAddr,
  input  logic [DATA_WIDTH-1:0] iMemRdData,
  output logic                  oMemWrEn,
  output logic [DATA_WIDTH-1:0] oMemWrAddr,
  output logic [DATA_WIDTH-1:0] oMemWrData,
  output logic [BYTE_WIDTH-1:0] oMemWrLen
);

  logic [1:0]            state;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  misalign_q;
  logic [DATA_WIDTH-1:0] ext_data;

  lsu_load_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_ext (
    .funct3 (funct3_q),
    .raw    (iMemRdData),
    .result (ext_data)
  );

  // Request capture, state sequencing and response registration
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state       <= ST_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iReqValid) begin
            write_q     <= iReqWrite;
            funct3_q    <= iReqFunct3;
            addr_q      <= iReqAddr;
            data_q      <= iReqData;
            resp_data_q <= '0;
            if (req_faults(iReqWrite, iReqFunct3, iReqAddr[2:0])) begin
              misalign_q <= 1'b1;
              state      <= ST_RESP;
            end else begin
              misalign_q <= 1'b0;
              state      <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          resp_data_q <= write_q ? '0 : ext_data;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (iRespReady) begin
            resp_data_q <= '0;
            misalign_q  <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oReqReady     = (state == ST_IDLE);
  assign oRespValid    = (state == ST_RESP);
  assign oRespData     = resp_data_q;
  assign oRespMisalign = misalign_q;

  // Enables are decoded from registered state only; gating by iReset keeps a
  // reset that lands during ACCESS from letting the access through.
  assign oMemRdEn   = (state == ST_ACCESS) && !write_q && !iReset;
  assign oMemWrEn   = (state == ST_ACCESS) &&  write_q && !iReset;
  assign oMemRdAddr = addr_q;
  assign oMemWrAddr = addr_q;
  assign oMemWrData = data_q;
  assign oMemWrLen  = {{(BYTE_WIDTH-1){1'b0}}, 1'b1} << funct3_q[1:0];

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load extension, store drive, faults,
// response back-pressure and reset during ACCESS.
module tb_lsu_mem_ctrl;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqWrite;
  logic [2:0]  iReqFunct3;
  logic [63:0] iReqAddr;
  logic [63:0] iReqData;
  logic        oRespValid;
  logic        iRespReady;
  logic [63:0] oRespData;
  logic        oRespMisalign;
  logic        oMemRdEn;
  logic [63:0] oMemRdAddr;
  logic [63:0] iMemRdData;
  logic        oMemWrEn;
  logic [63:0] oMemWrAddr;
  logic [63:0] oMemWrData;
  logic [7:0]  oMemWrLen;

  int vectors    = 0;
  int miscompares = 0;

  lsu_mem_ctrl #(
    .DATA_WIDTH (64),
    .BYTE_WIDTH (8)
  ) dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iReqValid     (iReqValid),
    .oReqReady     (oReqReady),
    .iReqWrite     (iReqWrite),
    .iReqFunct3    (iReqFunct3),
    .iReqAddr      (iReqAddr),
    .iReqData      (iReqData),
    .oRespValid    (oRespValid),
    .iRespReady    (iRespReady),
    .oRespData     (oRespData),
    .oRespMisalign (oRespMisalign),
    .oMemRdEn      (oMemRdEn),
    .oMemRdAddr    (oMemRdAddr),
    .iMemRdData    (iMemRdData),
    .oMemWrEn      (oMemWrEn),
    .oMemWrAddr    (oMemWrAddr),
    .oMemWrData    (oMemWrData),
    .oMemWrLen     (oMemWrLen)
  );

  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] data);
    iReqValid  = 1'b1;
    iReqWrite  = wr;
    iReqFunct3 = f3;
    iReqAddr   = addr;
    iReqData   = data;
  endtask

  initial begin
    iReset     = 1'b1;
    iReqValid  = 1'b0;
    iReqWrite  = 1'b0;
    iReqFunct3 = 3'b000;
    iReqAddr   = '0;
    iReqData   = '0;
    iRespReady = 1'b1;
    iMemRdData = '0;
    tick();
    tick();
    iReset = 1'b0;

    // Reset state
    chk("rst_reqready", 64'(oReqReady), 64'd1);
    chk("rst_respvalid", 64'(oRespValid), 64'd0);
    chk("rst_rden", 64'(oMemRdEn), 64'd0);
    chk("rst_wren", 64'(oMemWrEn), 64'd0);
    chk("rst_respdata", oRespData, 64'd0);
    chk("rst_misalign", 64'(oRespMisalign), 64'd0);

    // LB, sign-extended negative byte
    request(1'b0, 3'b000, 64'h8000_0003, 64'd0);
    iMemRdData = 64'h1234_5678_9ABC_DEF0;
    tick();
    iReqValid = 1'b0;
    chk("lb_acc_rden", 64'(oMemRdEn), 64'd1);
    chk("lb_acc_wren", 64'(oMemWrEn), 64'd0);
    chk("lb_acc_rdaddr", oMemRdAddr, 64'h8000_0003);
    chk("lb_acc_respvalid", 64'(oRespValid), 64'd0);
    chk("lb_acc_reqready", 64'(oReqReady), 64'd0);
    tick();
    chk("lb_resp_rden", 64'(oMemRdEn), 64'd0);
    chk("lb_resp_valid", 64'(oRespValid), 64'd1);
    chk("lb_resp_data", oRespData, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("lb_resp_misalign", 64'(oRespMisalign), 64'd0);
    tick();
    chk("lb_idle_reqready", 64'(oReqReady), 64'd1);
    chk("lb_idle_respvalid", 64'(oRespValid), 64'd0);

    // LHU, zero-extended
    request(1'b0, 3'b101, 64'h8000_0002, 64'd0);
    iMemRdData = 64'hAAAA_BBBB_CCCC_8001;
    tick();
    iReqValid = 1'b0;
    chk("lhu_acc_rden", 64'(oMemRdEn), 64'd1);
    tick();
    chk("lhu_resp_data", oRespData, 64'h0000_0000_0000_8001);
    chk("lhu_resp_misalign", 64'(oRespMisalign), 64'd0);
    tick();

    // LW, sign-extended
    request(1'b0, 3'b010, 64'h8000_0008, 64'd0);
    iMemRdData = 64'h1234_5678_8000_0000;
    tick();
    iReqValid = 1'b0;
    tick();
    chk("lw_resp_data", oRespData, 64'hFFFF_FFFF_8000_0000);
    tick();

    // SW: one-cycle write with full data and length 4
    request(1'b1, 3'b010, 64'h8000_1000, 64'h1122_3344_5566_7788);
    iMemRdData = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    iReqValid = 1'b0;
    chk("sw_acc_wren", 64'(oMemWrEn), 64'd1);
    chk("sw_acc_rden", 64'(oMemRdEn), 64'd0);
    chk("sw_acc_wraddr", oMemWrAddr, 64'h8000_1000);
    chk("sw_acc_wrdata", oMemWrData, 64'h1122_3344_5566_7788);
    chk("sw_acc_wrlen", 64'(oMemWrLen), 64'd4);
    tick();
    chk("sw_resp_wren", 64'(oMemWrEn), 64'd0);
    chk("sw_resp_valid", 64'(oRespValid), 64'd1);
    chk("sw_resp_data", oRespData, 64'd0);
    chk("sw_resp_misalign", 64'(oRespMisalign), 64'd0);
    tick();

    // LD misaligned: response at N+1, no memory access
    request(1'b0, 3'b011, 64'h8000_0004, 64'd0);
    iMemRdData = 64'h0123_4567_89AB_CDEF;
    tick();
    iReqValid = 1'b0;
    chk("ld_mis_rden", 64'(oMemRdEn), 64'd0);
    chk("ld_mis_wren", 64'(oMemWrEn), 64'd0);
    chk("ld_mis_valid", 64'(oRespValid), 64'd1);
    chk("ld_mis_flag", 64'(oRespMisalign), 64'd1);
    chk("ld_mis_data", oRespData, 64'd0);
    tick();
    chk("ld_mis_idle", 64'(oReqReady), 64'd1);

    // LH at odd address
    request(1'b0, 3'b001, 64'h8000_0001, 64'd0);
    tick();
    iReqValid = 1'b0;
    chk("lh_mis_flag", 64'(oRespMisalign), 64'd1);
    chk("lh_mis_rden", 64'(oMemRdEn), 64'd0);
    tick();

    // Illegal load funct3 111 at aligned address
    request(1'b0, 3'b111, 64'h8000_0000, 64'd0);
    tick();
    iReqValid = 1'b0;
    chk("ill_ld_flag", 64'(oRespMisalign), 64'd1);
    chk("ill_ld_rden", 64'(oMemRdEn), 64'd0);
    chk("ill_ld_valid", 64'(oRespValid), 64'd1);
    tick();

    // Illegal store funct3 100
    request(1'b1, 3'b100, 64'h8000_0000, 64'hDEAD);
    tick();
    iReqValid = 1'b0;
    chk("ill_st_flag", 64'(oRespMisalign), 64'd1);
    chk("ill_st_wren", 64'(oMemWrEn), 64'd0);
    tick();

    // LWU with response back-pressure and ignored request pulses
    iRespReady = 1'b0;
    request(1'b0, 3'b110, 64'h8000_0010, 64'd0);
    iMemRdData = 64'hDEAD_BEEF_F000_0001;
    tick();
    iReqValid = 1'b0;
    tick();
    chk("lwu_resp_data", oRespData, 64'h0000_0000_F000_0001);
    for (int i = 0; i < 5; i++) begin
      request(1'b1, 3'b011, 64'h8000_2000, 64'h5555);
      iMemRdData = 64'h0;
      tick();
      iReqValid = 1'b0;
      chk("hold_valid", 64'(oRespValid), 64'd1);
      chk("hold_data", oRespData, 64'h0000_0000_F000_0001);
      chk("hold_misalign", 64'(oRespMisalign), 64'd0);
      chk("hold_reqready", 64'(oReqReady), 64'd0);
      chk("hold_rden", 64'(oMemRdEn), 64'd0);
      chk("hold_wren", 64'(oMemWrEn), 64'd0);
    end
    iRespReady = 1'b1;
    tick();
    chk("release_reqready", 64'(oReqReady), 64'd1);
    chk("release_respvalid", 64'(oRespValid), 64'd0);

    // SD with reset asserted during ACCESS
    request(1'b1, 3'b011, 64'h8000_2000, 64'hCAFE_F00D_1234_5678);
    tick();
    iReqValid = 1'b0;
    chk("sd_acc_wren", 64'(oMemWrEn), 64'd1);
    chk("sd_acc_wrlen", 64'(oMemWrLen), 64'd8);
    iReset = 1'b1;
    #1;
    chk("sd_rst_wren", 64'(oMemWrEn), 64'd0);
    tick();
    iReset = 1'b0;
    chk("sd_rst_reqready", 64'(oReqReady), 64'd1);
    chk("sd_rst_respvalid", 64'(oRespValid), 64'd0);
    chk("sd_rst_wren2", 64'(oMemWrEn), 64'd0);
    chk("sd_rst_rden", 64'(oMemRdEn), 64'd0);
    chk("sd_rst_respdata", oRespData, 64'd0);
    chk("sd_rst_misalign", 64'(oRespMisalign), 64'd0);
    chk("sd_rst_wraddr", oMemWrAddr, 64'd0);
    chk("sd_rst_wrdata", oMemWrData, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
